ebi_mailbox: RTL and testbench
==============================

// Module: ebi_mailbox
// PURPOSE
//  Register-mapped mailbox consuming the one-cycle read/write strobes and 22-bit word address
//  produced by the PPC EBI front end. Writes to DATA push a 32-bit TX FIFO drained to the peer
//  core; reads of DATA pop an RX FIFO filled by the peer. Adds status/IRQ registers so each core
//  of the dual-core system exchanges messages without polling raw memory.
// PARAMETERS
//  BASE_WADDR  22'h000000  word address of register 0; block decodes BASE_WADDR..BASE_WADDR+3
//  DEPTH       16          entries per FIFO, power of 2, 2..128
//  POP_DELAY   4           cycles from DATA read strobe to RX pop (holds rdata for EBI cycle), >=1
// PORTS
//  clk       in   1   system clock
//  rst       in   1   asynchronous reset, active-high
//  re_i      in   1   single-cycle read strobe from EBI front end
//  we_i      in   1   single-cycle write strobe from EBI front end
//  addr_i    in   22  word address (EBI A31..A10)
//  wdata_i   in   32  EBI write data, valid when we_i=1
//  rdata_o   out  32  read data to EBI data bus
//  irq_o     out  1   level interrupt to this core
//  tx_data_o out  32  message word to peer
//  tx_valid_o out 1   TX head valid
//  tx_ready_i in  1   peer accepts TX head (transfer when valid&ready)
//  rx_data_i in   32  message word from peer
//  rx_valid_i in  1   peer offers word
//  rx_ready_o out 1   RX FIFO not full (transfer when valid&ready)
// BEHAVIOUR
//  Register map (offset = addr_i - BASE_WADDR; other addresses: writes ignored, reads 0):
//   0 DATA   W: push TX   R: RX head (0 if empty), schedules pop
//   1 STATUS R: [7:0] rx_count [15:8] tx_count [16] rx_empty [17] tx_full; W ignored
//   2 IRQ_EN R/W [3:0]
//   3 IRQ_ST R: [0] rx_nonempty (level) [1] tx_empty (level) [2] tx_ovf [3] rx_unf; W1C bits 2,3
//  irq_o = |(IRQ_ST & IRQ_EN), registered (1 cycle after status change).
//  Reset: both FIFOs empty, counts 0, IRQ_EN=0, sticky bits 0, pop counter 0, rdata_o=0,
//   irq_o=0, tx_valid_o=0, rx_ready_o=1.
//  rdata_o: combinational mux of addr_i; DATA returns current RX head; stable until pop.
//  Write DATA with TX full: word dropped, tx_ovf<=1. Write with tx_ready_i draining same cycle:
//   count unchanged, word accepted.
//  Read DATA with RX empty: returns 0, rx_unf<=1, no pop scheduled.
//  Pop timer: DATA read with RX non-empty loads counter=POP_DELAY; decrements each cycle;
//   pop at transition 1->0. Second DATA read while counter!=0: pending pop executes that cycle,
//   counter reloads (new pop only if FIFO still non-empty after first pop).
//  Simultaneous RX push (peer) and pop: count unchanged; push into full FIFO impossible
//   (rx_ready_o=0). Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1, zero-extended to 8.
//  Simultaneous W1C write and new sticky event same cycle: event wins (bit stays 1).
//  re_i and we_i never both high; if so, write takes priority, read ignored.
//  Reset mid-operation: all state cleared immediately, pending pop discarded.
// STRUCTURE
//  Package ebi_mailbox_pkg: register offsets, STATUS/IRQ bit indices, DATA_W=32, ADDR_W=22.
//  One sub-module: mb_sync_fifo (DEPTH, WIDTH; push/pop/full/empty/count/head), instanced
//  twice (TX, RX). Decode, pop timer, IRQ logic in top.
// TESTING
//  1 Write DATA 0xDEADBEEF, 0x12345678, tx_ready_i=1 -> tx_data_o sequence DEADBEEF,12345678; tx_count 2->0.
//  2 Peer pushes 0xA5A5A5A5; read DATA -> rdata 0xA5A5A5A5 held POP_DELAY cycles, then
//    rx_count 1->0, rx_empty=1.
//  3 Fill TX to DEPTH with tx_ready_i=0, one more write -> dropped, tx_ovf=1; write IRQ_ST
//    0x4 -> tx_ovf=0.
//  4 Read DATA on empty RX -> rdata 0, rx_unf=1; IRQ_EN=0x8 -> irq_o=1 next cycle.
//  5 Two DATA reads 2 cycles apart with 3 RX entries -> first pop immediate at 2nd read,
//    second pop POP_DELAY later; rx_count 3->2->1.
//  6 Assert rst during pending pop with RX non-empty -> all counts 0, irq_o=0, no pop after release.

Source files
------------

// File: rtl/ebi_mailbox_pkg.sv
// Shared constants for the EBI mailbox: register offsets, bit positions, bus widths.
package ebi_mailbox_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 22;
  localparam int IRQ_W  = 4;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_IRQ_EN = 2'd2,
    REG_IRQ_ST = 2'd3
  } reg_off_e;

  localparam int ST_RX_EMPTY = 16;
  localparam int ST_TX_FULL  = 17;

  localparam int IRQ_RX_NONEMPTY = 0;
  localparam int IRQ_TX_EMPTY    = 1;
  localparam int IRQ_TX_OVF      = 2;
  localparam int IRQ_RX_UNF      = 3;

endpackage

// File: rtl/mb_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored.
module mb_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    // DEPTH is a power of two, so the pointers wrap on their own.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; contents are only visible through count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ebi_mailbox.sv
// EBI register-mapped mailbox: DATA/STATUS/IRQ_EN/IRQ_ST decode, TX and RX FIFOs,
// delayed RX pop so the read word stays on the bus for the whole EBI cycle.
module ebi_mailbox
  import ebi_mailbox_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_WADDR = '0,
  parameter int                DEPTH      = 16,
  parameter int                POP_DELAY  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              irq_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam int              TW         = $clog2(POP_DELAY + 1);
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(POP_DELAY);

  logic [ADDR_W-1:0] offset;
  logic              hit;
  reg_off_e          reg_sel;
  logic              wr_en, rd_en, data_wr, data_rd, irq_en_wr, irq_st_wr;

  logic              tx_full, tx_empty, tx_pop;
  logic [CW-1:0]     tx_count;
  logic              rx_full, rx_empty, rx_push, rx_pop;
  logic [CW-1:0]     rx_count;
  logic [DATA_W-1:0] rx_head;

  logic [TW-1:0]     timer_q, timer_d;
  logic [IRQ_W-1:0]  irq_en_q, irq_en_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, irq_q, irq_d;
  logic              ovf_set, unf_set;
  logic [IRQ_W-1:0]  irq_st;

  assign offset    = addr_i - BASE_WADDR;
  assign hit       = (offset[ADDR_W-1:2] == '0);
  assign reg_sel   = reg_off_e'(offset[1:0]);
  // A write strobe wins if the front end ever raises both.
  assign wr_en     = we_i & hit;
  assign rd_en     = re_i & ~we_i & hit;
  assign data_wr   = wr_en & (reg_sel == REG_DATA);
  assign data_rd   = rd_en & (reg_sel == REG_DATA);
  assign irq_en_wr = wr_en & (reg_sel == REG_IRQ_EN);
  assign irq_st_wr = wr_en & (reg_sel == REG_IRQ_ST);

  assign tx_valid_o = ~tx_empty;
  assign tx_pop     = tx_valid_o & tx_ready_i;
  assign rx_ready_o = ~rx_full;
  assign rx_push    = rx_valid_i & rx_ready_o;
  assign irq_o      = irq_q;

  mb_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(data_wr), .data_i(wdata_i), .pop_i(tx_pop),
    .head_o(tx_data_o), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  mb_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .data_i(rx_data_i), .pop_i(rx_pop),
    .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  always_comb begin
    timer_d = timer_q;
    rx_pop  = 1'b0;
    unf_set = 1'b0;
    if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
      rx_pop  = (timer_q == TW'(1));
    end
    // A DATA read while a pop is pending forces that pop now and rearms for the next word.
    if (data_rd) begin
      if (timer_q != '0) begin
        rx_pop  = 1'b1;
        timer_d = ((rx_count > CW'(1)) || rx_push) ? TIMER_LOAD : '0;
      end else if (!rx_empty) begin
        timer_d = TIMER_LOAD;
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  always_comb begin
    ovf_set  = data_wr & tx_full;
    // Set terms are ORed last so a new event beats a simultaneous W1C.
    ovf_d    = (ovf_q & ~(irq_st_wr & wdata_i[IRQ_TX_OVF])) | ovf_set;
    unf_d    = (unf_q & ~(irq_st_wr & wdata_i[IRQ_RX_UNF])) | unf_set;
    irq_en_d = irq_en_wr ? wdata_i[IRQ_W-1:0] : irq_en_q;
    irq_st   = '0;
    irq_st[IRQ_RX_NONEMPTY] = ~rx_empty;
    irq_st[IRQ_TX_EMPTY]    = tx_empty;
    irq_st[IRQ_TX_OVF]      = ovf_q;
    irq_st[IRQ_RX_UNF]      = unf_q;
    irq_d    = |(irq_st & irq_en_q);
  end

  always_comb begin
    rdata_o = '0;
    if (hit) begin
      case (reg_sel)
        REG_DATA:   rdata_o = rx_empty ? '0 : rx_head;
        REG_STATUS: begin
          rdata_o[7:0]        = 8'(rx_count);
          rdata_o[15:8]       = 8'(tx_count);
          rdata_o[ST_RX_EMPTY] = rx_empty;
          rdata_o[ST_TX_FULL]  = tx_full;
        end
        REG_IRQ_EN: rdata_o[IRQ_W-1:0] = irq_en_q;
        REG_IRQ_ST: rdata_o[IRQ_W-1:0] = irq_st;
        default:    rdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      irq_en_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_ebi_mailbox.sv
// Bench for ebi_mailbox: queue-based reference model feeds a scoreboard that a negedge
// monitor drains; directed scenarios first, then randomized traffic.
module tb_ebi_mailbox;
  import ebi_mailbox_pkg::*;

  localparam logic [21:0] BASE      = 22'h000040;
  localparam int          DEPTH     = 16;
  localparam int          POP_DELAY = 4;

  logic        clk, rst, re_i, we_i, tx_ready_i, rx_valid_i;
  logic [21:0] addr_i;
  logic [31:0] wdata_i, rdata_o, tx_data_o, rx_data_i;
  logic        irq_o, tx_valid_o, rx_ready_o;

  ebi_mailbox #(.BASE_WADDR(BASE), .DEPTH(DEPTH), .POP_DELAY(POP_DELAY)) dut (
    .clk(clk), .rst(rst), .re_i(re_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .irq_o(irq_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        irq;
    logic        tx_valid;
    logic        rx_ready;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        cyc_q[$];
  logic [31:0] tx_sb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model state
  logic [31:0] m_tx[$];
  logic [31:0] m_rx[$];
  logic [3:0]  m_en;
  logic        m_ovf, m_unf, m_irq;
  longint      cyc = 0;
  longint      pop_due = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [21:0] a);
    logic [21:0] off;
    logic [31:0] r;
    off = a - BASE;
    r = '0;
    if (off <= 22'd3) begin
      case (off)
        22'd0: r = (m_rx.size() != 0) ? m_rx[0] : 32'h0;
        22'd1: r = {14'b0, m_tx.size() == DEPTH, m_rx.size() == 0,
                    8'(m_tx.size()), 8'(m_rx.size())};
        22'd2: r = {28'b0, m_en};
        default: r = {28'b0, m_unf, m_ovf, m_tx.size() == 0, m_rx.size() != 0};
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_tx.delete(); m_rx.delete(); tx_sb.delete();
    m_en = '0; m_ovf = 0; m_unf = 0; m_irq = 0; pop_due = -1;
  endtask

  // One bus cycle: drive inputs, queue the expected outputs, advance the model past the edge.
  task automatic step(input logic we, input logic re, input logic [21:0] a, input logic [31:0] wd,
                      input logic txr, input logic rxv, input logic [31:0] rxd, input logic peek);
    exp_t        e;
    logic [21:0] off;
    logic        wr, rd, tx_full_pre, rx_push, do_pop, ovf_set, unf_set, nirq;
    logic [3:0]  st;
    @(posedge clk);
    #2;
    rst = 1'b0; we_i = we; re_i = re; addr_i = a; wdata_i = wd;
    tx_ready_i = txr; rx_valid_i = rxv; rx_data_i = rxd;
    e.irq      = m_irq;
    e.tx_valid = (m_tx.size() != 0);
    e.rx_ready = (m_rx.size() < DEPTH);
    e.chk_rd   = (re && !we) || peek;
    e.rdata    = model_read(a);
    cyc_q.push_back(e);

    off = a - BASE;
    wr  = we && (off <= 22'd3);
    rd  = re && !we && (off <= 22'd3);
    st  = {m_unf, m_ovf, m_tx.size() == 0, m_rx.size() != 0};
    nirq = |(st & m_en);
    ovf_set = 0; unf_set = 0;
    tx_full_pre = (m_tx.size() == DEPTH);
    if (txr && m_tx.size() != 0) void'(m_tx.pop_front());
    if (wr && off == 22'd0) begin
      if (tx_full_pre) ovf_set = 1;
      else begin m_tx.push_back(wd); tx_sb.push_back(wd); end
    end
    rx_push = rxv && (m_rx.size() < DEPTH);
    do_pop  = (pop_due == cyc);
    if (do_pop) pop_due = -1;
    if (rd && off == 22'd0) begin
      if (do_pop || pop_due > cyc) begin
        do_pop  = 1;
        pop_due = ((m_rx.size() - 1 + int'(rx_push)) > 0) ? cyc + POP_DELAY : -1;
      end else if (m_rx.size() != 0) begin
        pop_due = cyc + POP_DELAY;
      end else begin
        unf_set = 1;
      end
    end
    if (do_pop) void'(m_rx.pop_front());
    if (rx_push) m_rx.push_back(rxd);
    if (wr && off == 22'd2) m_en = wd[3:0];
    if (wr && off == 22'd3) begin
      m_ovf = m_ovf & ~wd[2];
      m_unf = m_unf & ~wd[3];
    end
    m_ovf = m_ovf | ovf_set;
    m_unf = m_unf | unf_set;
    m_irq = nirq;
    cyc++;
  endtask

  task automatic reset_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      rst = 1'b1; we_i = 0; re_i = 0; addr_i = BASE; wdata_i = '0;
      tx_ready_i = 0; rx_valid_i = 0; rx_data_i = '0;
      model_reset();
      e = '{irq: 1'b0, tx_valid: 1'b0, rx_ready: 1'b1, chk_rd: 1'b1, rdata: 32'h0};
      cyc_q.push_back(e);
      cyc++;
    end
  endtask

  task automatic wr_reg(input int off, input logic [31:0] d, input logic txr);
    step(1, 0, BASE + 22'(off), d, txr, 0, '0, 0);
  endtask
  task automatic rd_reg(input int off);
    step(0, 1, BASE + 22'(off), '0, 0, 0, '0, 0);
  endtask
  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) step(0, 0, BASE + 22'd1, '0, txr, 0, '0, 0);
  endtask
  task automatic peer_push(input logic [31:0] d);
    step(0, 0, BASE + 22'd1, '0, 0, 1, d, 0);
  endtask
  task automatic peek_data();
    step(0, 0, BASE, '0, 0, 0, '0, 1);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (cyc_q.size() != 0) begin
      e = cyc_q.pop_front();
      check("irq_o", {31'b0, irq_o}, {31'b0, e.irq});
      check("tx_valid_o", {31'b0, tx_valid_o}, {31'b0, e.tx_valid});
      check("rx_ready_o", {31'b0, rx_ready_o}, {31'b0, e.rx_ready});
      if (e.chk_rd) check("rdata_o", rdata_o, e.rdata);
    end
    if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
      if (tx_sb.size() != 0) check("tx_data_o", tx_data_o, tx_sb.pop_front());
      else begin
        n_cmp++; n_err++;
        $display("FAIL tx_data_o: unexpected transfer %h, none expected at %0t", tx_data_o, $time);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sel;
    logic txr_bias;
    rst = 1'b1; re_i = 0; we_i = 0; addr_i = BASE; wdata_i = '0;
    tx_ready_i = 0; rx_valid_i = 0; rx_data_i = '0;
    model_reset();
    reset_cycles(3);
    rd_reg(1); rd_reg(3); rd_reg(0);

    // TX ordering and count
    wr_reg(0, 32'hDEADBEEF, 0);
    wr_reg(0, 32'h12345678, 0);
    rd_reg(1);
    idle(3, 1);
    rd_reg(1);

    // RX read holds data until the delayed pop
    peer_push(32'hA5A5A5A5);
    rd_reg(1);
    rd_reg(0);
    for (int i = 0; i < POP_DELAY + 1; i++) peek_data();
    rd_reg(1);

    // TX overflow and W1C
    for (int i = 0; i < DEPTH + 1; i++) wr_reg(0, 32'h1000_0000 + 32'(i), 0);
    rd_reg(1); rd_reg(3);
    wr_reg(3, 32'h4, 0);
    rd_reg(3);
    idle(DEPTH + 2, 1);

    // RX underflow raises irq
    rd_reg(0);
    rd_reg(3);
    wr_reg(2, 32'h8, 0);
    idle(3, 0);
    wr_reg(3, 32'h8, 0);
    idle(2, 0);
    wr_reg(2, 32'h0, 0);

    // Back-to-back DATA reads with three entries queued
    peer_push(32'h0000_0001); peer_push(32'h0000_0002); peer_push(32'h0000_0003);
    rd_reg(0);
    rd_reg(1);
    rd_reg(0);
    for (int i = 0; i < POP_DELAY + 2; i++) rd_reg(1);
    rd_reg(0); idle(POP_DELAY + 1, 0);

    // Reset during pending pop
    peer_push(32'hCAFE0001); peer_push(32'hCAFE0002);
    rd_reg(0);
    idle(1, 0);
    reset_cycles(2);
    idle(POP_DELAY + 2, 0);
    rd_reg(1); rd_reg(3);

    // Decode edges and strobe priority
    rd_reg(4); step(0, 1, BASE - 22'd1, '0, 0, 0, '0, 0);
    wr_reg(5, 32'hFFFF_FFFF, 0); rd_reg(2);
    step(1, 1, BASE, 32'h5151_5151, 0, 0, '0, 0);
    rd_reg(1);
    idle(3, 1);

    // Randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      txr_bias = blk[0];
      for (int i = 0; i < 500; i++) begin
        logic        txr, rxv;
        logic [31:0] d, rxd;
        logic [21:0] a;
        sel = $urandom_range(0, 9);
        txr = txr_bias ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
        rxv = ($urandom_range(0, 1) == 1);
        d   = $urandom;
        rxd = $urandom;
        case (sel)
          0, 1, 2: step(0, 1, BASE, '0, txr, rxv, rxd, 0);
          3:       step(1, 0, BASE, d, txr, rxv, rxd, 0);
          4:       step(0, 1, BASE + 22'd1, '0, txr, rxv, rxd, 0);
          5:       step($urandom_range(0, 1) == 1, 1, BASE + 22'd3, d, txr, rxv, rxd, 0);
          6:       step($urandom_range(0, 1) == 1, 1, BASE + 22'd2, d, txr, rxv, rxd, 0);
          7: begin
            a = ($urandom_range(0, 1) == 1) ? BASE + 22'($urandom_range(4, 300))
                                            : BASE - 22'($urandom_range(1, 60));
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d, txr, rxv, rxd, 1);
          end
          default: step(0, 0, BASE, '0, txr, rxv, rxd, 1);
        endcase
      end
      if (blk == 3) reset_cycles(1);
    end
    idle(DEPTH + 2, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
